secuenciador_motor: RTL and testbench
=====================================

Name: secuenciador_motor

Overview:
Step/phase controller for the 4-coil stepper that drives the timer's motor output.
- Sequences the coil pattern at a programmable step rate in full-step or half-step mode, either direction.
- Stops on a step-count target, a stop command, or the filtered end-of-travel sensor.
- Holds the coils energized for a settle period, then releases them. The timer logic issues start/stop; this block owns the motor outputs.

Parameters:
STEP_DIV, 50000, clk cycles per step period (>=2)
HOLD_CYC, 1000, clk cycles coils stay energized after motion ends (>=1)
SENSOR_FILT, 3, consecutive synchronized samples required to accept a sensor level change
CNT_W, 12, width of step target/count

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin motion
stop  in  1  one-cycle pulse: abort motion
dir  in  1  1 = forward (index increments), 0 = reverse; sampled at start
half_step  in  1  1 = half-step, 0 = full-step; sampled at start
n_steps  in  CNT_W  step target; 0 = run until sensor/stop; sampled at start
sensor  in  1  asynchronous end-of-travel input, active high
coils  out  4  coil drive pattern
busy  out  1  high in RUN and HOLD
done  out  1  one-cycle pulse on return to IDLE
sensor_hit  out  1  motion ended by sensor; cleared at next accepted start
step_count  out  CNT_W  steps taken since last accepted start

Behaviour:
- Reset: coils=0000, busy=0, done=0, sensor_hit=0, step_count=0, phase index=0, prescaler=0, state=IDLE. Reset mid-motion de-energizes the coils immediately (asynchronous).
- Sensor path: 2-flop synchronizer feeding a filter. The filtered level changes only after SENSOR_FILT equal consecutive samples.
- Phase table, 3-bit index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Half-step: index moves ±1 per step. Full-step: index moves ±2. At start in full-step with an even index, index is first set to index|1, so only two-coil patterns are used.
- States: IDLE, RUN, HOLD.
- IDLE: coils=0000.
  - start (stop not asserted, filtered sensor low) -> RUN. Latch dir/half_step/n_steps, clear step_count and sensor_hit, clear prescaler. Coils show table[index] from the next cycle.
  - start with filtered sensor high -> remain IDLE; pulse done and set sensor_hit one cycle later; no coil activity.
  - start and stop in the same cycle -> ignored.
- RUN: prescaler counts 0..STEP_DIV-1. At the terminal count, index advances and step_count increments, so the first step lands STEP_DIV cycles after RUN entry.
  - Exits to HOLD (prescaler cleared, index frozen):
    - filtered sensor high -> also set sensor_hit.
    - stop.
    - step_count reaches n_steps (n_steps != 0), evaluated after the increment.
  - Priority when events coincide: sensor > stop > terminal step. A step coinciding with sensor or stop is not taken.
  - start while busy is ignored.
- HOLD: coils=table[index] for HOLD_CYC cycles, then -> IDLE with a done pulse in the cycle coils become 0000. start/stop are ignored in HOLD.
- step_count saturates at all-ones in continuous mode; stepping continues.

Optional Feature:
RAMP_EN. When defined, each motion uses an accelerated step profile: step 1 period = 4*STEP_DIV, step 2 = 2*STEP_DIV, remaining steps = STEP_DIV. The prescaler is widened accordingly. When undefined, every period is STEP_DIV and the ramp logic is absent.

Decomposition:
- Package motor_pkg: state encoding (IDLE/RUN/HOLD), 8-entry phase table constant, default parameter constants.
- One sub-module, filtro_sensor: 2-flop synchronizer plus SENSOR_FILT consecutive-sample filter, output filtered level.

Test Plan:
Parameters for all scenarios: STEP_DIV=4, HOLD_CYC=8, SENSOR_FILT=3.
- Reset release -> coils=0000, busy=0, done=0, step_count=0; start pulse with sensor low -> busy=1 next cycle.
- From index 0: half_step=1, dir=1, n_steps=5, start -> coils 0001 then 0011, 0010, 0110, 0100, 1100 each 4 cycles apart; step_count=5; 1100 held 8 cycles; done pulse; coils=0000.
- From index 0: half_step=0, dir=0, n_steps=3 -> coils 0011, then 1001, 1100, 0110; done; sensor_hit=0.
- n_steps=0 running, sensor high 3+ cycles -> enters HOLD within 2+3 cycles of assertion, step_count frozen, sensor_hit=1. A separate 2-cycle sensor glitch causes no stop.
- start and stop in the same IDLE cycle -> no motion, no done. stop mid-RUN -> HOLD, then done after 8 cycles.
- rst_n low mid-RUN -> coils=0000 without waiting for a clk edge. With RAMP_EN defined: first three step intervals are 16, 8, 4 cycles.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the stepper sequencer: controller states, coil phase table
// and default parameter values.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } motorState_e;

    // Index 0 is the rightmost entry; odd indices energize two coils.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    localparam int DEF_STEP_DIV    = 50000;
    localparam int DEF_HOLD_CYC    = 1000;
    localparam int DEF_SENSOR_FILT = 3;
    localparam int DEF_CNT_W       = 12;

endpackage

// File: rtl/filtro_sensor.sv
// End-of-travel sensor conditioning: two-flop synchronizer followed by a filter that
// accepts a new level only after SENSOR_FILT equal consecutive synchronized samples.
module filtro_sensor #(
    parameter int SENSOR_FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    output logic sensorFilt
);

    localparam int CW = $clog2(SENSOR_FILT + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] matchCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
        end
    end

    // Any sample equal to the current level restarts the run of differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matchCnt   <= '0;
            sensorFilt <= 1'b0;
        end else if (sync2 == sensorFilt) begin
            matchCnt <= '0;
        end else if (matchCnt == CW'(SENSOR_FILT - 1)) begin
            matchCnt   <= '0;
            sensorFilt <= sync2;
        end else begin
            matchCnt <= matchCnt + 1'b1;
        end
    end

endmodule

// File: rtl/secuenciador_motor.sv
// Stepper phase sequencer: runs the coil pattern at a programmable rate until target,
// stop or sensor, holds the coils for a settle period, then releases them. Optional RAMP_EN.
module secuenciador_motor
    import motor_pkg::*;
#(
    parameter int STEP_DIV    = DEF_STEP_DIV,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int SENSOR_FILT = DEF_SENSOR_FILT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             half_step,
    input  logic [CNT_W-1:0] n_steps,
    input  logic             sensor,
    output logic [3:0]       coils,
    output logic             busy,
    output logic             done,
    output logic             sensor_hit,
    output logic [CNT_W-1:0] step_count
);

`ifdef RAMP_EN
    localparam int PRESC_W = $clog2(4 * STEP_DIV);
`else
    localparam int PRESC_W = $clog2(STEP_DIV);
`endif
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    motorState_e        state;
    motorState_e        stateNext;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] prescLast;
    logic [HOLD_W-1:0]  holdCnt;
    logic [2:0]         idx;
    logic [2:0]         idxNext;
    logic [CNT_W-1:0]   stepCount;
    logic [CNT_W-1:0]   stepCountInc;
    logic [CNT_W-1:0]   nTarget;
    logic               dirQ;
    logic               halfQ;
    logic               sensorHit;
    logic               doneQ;
    logic               sensorFilt;
    logic               acceptStart;
    logic               rejectStart;
    logic               stepTick;
    logic               hitSensor;
    logic               holdEnd;

    filtro_sensor #(.SENSOR_FILT(SENSOR_FILT)) uFiltro (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor     (sensor),
        .sensorFilt (sensorFilt)
    );

`ifdef RAMP_EN
    // The first two steps of each motion use longer periods to ease the load into motion.
    always_comb begin
        prescLast = PRESC_W'(STEP_DIV - 1);
        if (stepCount == '0)
            prescLast = PRESC_W'(4 * STEP_DIV - 1);
        else if (stepCount == CNT_W'(1))
            prescLast = PRESC_W'(2 * STEP_DIV - 1);
    end
`else
    assign prescLast = PRESC_W'(STEP_DIV - 1);
`endif

    assign stepCountInc = (stepCount == '1) ? stepCount : stepCount + 1'b1;
    assign idxNext      = dirQ ? idx + (halfQ ? 3'd1 : 3'd2) : idx - (halfQ ? 3'd1 : 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Event priority in RUN is sensor, then stop, then the terminal step.
    always_comb begin
        stateNext   = state;
        acceptStart = 1'b0;
        rejectStart = 1'b0;
        stepTick    = 1'b0;
        hitSensor   = 1'b0;
        holdEnd     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (sensorFilt) begin
                        rejectStart = 1'b1;
                    end else begin
                        acceptStart = 1'b1;
                        stateNext   = RUN;
                    end
                end
            end
            RUN: begin
                if (sensorFilt) begin
                    hitSensor = 1'b1;
                    stateNext = HOLD;
                end else if (stop) begin
                    stateNext = HOLD;
                end else if (presc == prescLast) begin
                    stepTick = 1'b1;
                    if (nTarget != '0 && stepCountInc == nTarget)
                        stateNext = HOLD;
                end
            end
            HOLD: begin
                if (holdCnt == HOLD_W'(HOLD_CYC - 1)) begin
                    holdEnd   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            holdCnt   <= '0;
            idx       <= 3'd0;
            stepCount <= '0;
            nTarget   <= '0;
            dirQ      <= 1'b0;
            halfQ     <= 1'b0;
            sensorHit <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            doneQ <= holdEnd | rejectStart;
            if (acceptStart) begin
                dirQ      <= dir;
                halfQ     <= half_step;
                nTarget   <= n_steps;
                stepCount <= '0;
                sensorHit <= 1'b0;
                presc     <= '0;
                if (!half_step)
                    idx <= idx | 3'd1;
            end
            if (rejectStart || hitSensor)
                sensorHit <= 1'b1;
            if (state == RUN)
                presc <= (stepTick || stateNext != RUN) ? '0 : presc + 1'b1;
            if (stepTick) begin
                idx       <= idxNext;
                stepCount <= stepCountInc;
            end
            holdCnt <= (state == HOLD) ? holdCnt + 1'b1 : '0;
        end
    end

    assign coils      = (state == IDLE) ? 4'b0000 : PHASE_TABLE[idx];
    assign busy       = (state != IDLE);
    assign done       = doneQ;
    assign sensor_hit = sensorHit;
    assign step_count = stepCount;

endmodule

// File: tb/tb_secuenciador_motor.sv
// Self-checking bench for secuenciador_motor: directed scenarios plus random motions
// compared against a step-level reference model of the phase sequence.
module tb_secuenciador_motor;

    localparam int STEP_DIV    = 4;
    localparam int HOLD_CYC    = 8;
    localparam int SENSOR_FILT = 3;
    localparam int CNT_W       = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             dir = 1'b0;
    logic             half_step = 1'b0;
    logic [CNT_W-1:0] n_steps = '0;
    logic             sensor = 1'b0;
    logic [3:0]       coils;
    logic             busy;
    logic             done;
    logic             sensor_hit;
    logic [CNT_W-1:0] step_count;

    int checks = 0;
    int failures = 0;
    int modelIdx = 0;
    logic [3:0] phaseRef [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0100, 4'b1100, 4'b1000, 4'b1001};

    always #5 clk = ~clk;

    secuenciador_motor #(
        .STEP_DIV    (STEP_DIV),
        .HOLD_CYC    (HOLD_CYC),
        .SENSOR_FILT (SENSOR_FILT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .half_step  (half_step),
        .n_steps    (n_steps),
        .sensor     (sensor),
        .coils      (coils),
        .busy       (busy),
        .done       (done),
        .sensor_hit (sensor_hit),
        .step_count (step_count)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int stepPeriod(input int k);
`ifdef RAMP_EN
        if (k == 1) return 4 * STEP_DIV;
        if (k == 2) return 2 * STEP_DIV;
`endif
        return STEP_DIV;
    endfunction

    // Number of steps whose landing time (cycles after RUN entry) is strictly before t.
    function automatic int stepsBefore(input int t);
        int acc = 0;
        for (int k = 1; k < 1000; k++) begin
            acc += stepPeriod(k);
            if (acc >= t) return k - 1;
        end
        return 0;
    endfunction

    function automatic int advance(input int idxIn, input logic d, input logic h, input int n);
        int delta = h ? 1 : 2;
        return d ? (idxIn + n * delta) % 8 : (idxIn + 8 * n - n * delta) % 8;
    endfunction

    task automatic applyStimulus(input logic s, input logic p, input logic d, input logic h, input int n);
        start     = s;
        stop      = p;
        dir       = d;
        half_step = h;
        n_steps   = CNT_W'(n);
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelIdx = 0;
        tick(1);
    endtask

    task automatic runMotion(input logic d, input logic h, input int n);
        if (!h && (modelIdx % 2 == 0)) modelIdx = modelIdx + 1;
        applyStimulus(1'b1, 1'b0, d, h, n);
        checkOutput("busyAfterStart", 32'(busy), 32'(1));
        checkOutput("coilsAtStart", 32'(coils), 32'(phaseRef[modelIdx]));
        checkOutput("sensorHitCleared", 32'(sensor_hit), 32'(0));
        for (int k = 1; k <= n; k++) begin
            tick(stepPeriod(k) - 1);
            checkOutput("coilsBeforeStep", 32'(coils), 32'(phaseRef[modelIdx]));
            tick(1);
            modelIdx = advance(modelIdx, d, h, 1);
            checkOutput("coilsAfterStep", 32'(coils), 32'(phaseRef[modelIdx]));
            checkOutput("stepCount", 32'(step_count), 32'(k));
        end
        tick(HOLD_CYC - 1);
        checkOutput("coilsHeld", 32'(coils), 32'(phaseRef[modelIdx]));
        checkOutput("busyInHold", 32'(busy), 32'(1));
        checkOutput("noEarlyDone", 32'(done), 32'(0));
        tick(1);
        checkOutput("donePulse", 32'(done), 32'(1));
        checkOutput("coilsReleased", 32'(coils), 32'(0));
        checkOutput("busyCleared", 32'(busy), 32'(0));
        checkOutput("finalCount", 32'(step_count), 32'(n));
        tick(1);
        checkOutput("doneOneCycle", 32'(done), 32'(0));
    endtask

    initial begin
        int waited;
        int expSteps;

        #1;
        checkOutput("resetCoils", 32'(coils), 32'(0));
        checkOutput("resetBusy", 32'(busy), 32'(0));
        checkOutput("resetDone", 32'(done), 32'(0));
        checkOutput("resetCount", 32'(step_count), 32'(0));
        checkOutput("resetSensorHit", 32'(sensor_hit), 32'(0));
        #3;
        rst_n = 1'b1;
        tick(2);

        runMotion(1'b1, 1'b1, 5);
        doReset();
        runMotion(1'b0, 1'b0, 3);

        repeat (6) runMotion(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));

        // Continuous run: a 2-cycle glitch must be ignored, a long sensor pulse must stop it.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0);
        tick(1);
        sensor = 1'b1;
        tick(2);
        sensor = 1'b0;
        tick(6);
        sensor = 1'b1;
        waited = 0;
        while (!done && waited < 30) begin
            tick(1);
            waited++;
        end
        checkOutput("sensorStopDone", 32'(done), 32'(1));
        checkOutput("sensorStopLatency",
                    32'(waited >= 2 + SENSOR_FILT + HOLD_CYC && waited <= 3 + SENSOR_FILT + HOLD_CYC), 32'(1));
        expSteps = stepsBefore(9 + 2 + SENSOR_FILT);
        modelIdx = advance(modelIdx, 1'b1, 1'b1, expSteps);
        checkOutput("sensorStepsFrozen", 32'(step_count), 32'(expSteps));
        checkOutput("sensorHitSet", 32'(sensor_hit), 32'(1));
        checkOutput("sensorCoilsOff", 32'(coils), 32'(0));
        tick(1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5);
        checkOutput("blockedStartDone", 32'(done), 32'(1));
        checkOutput("blockedStartBusy", 32'(busy), 32'(0));
        checkOutput("blockedStartCoils", 32'(coils), 32'(0));
        checkOutput("blockedStartHit", 32'(sensor_hit), 32'(1));
        sensor = 1'b0;
        tick(8);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3);
        checkOutput("startStopBusy", 32'(busy), 32'(0));
        tick(2);
        checkOutput("startStopNoDone", 32'(done), 32'(0));
        checkOutput("startStopHitKept", 32'(sensor_hit), 32'(1));

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0);
        checkOutput("stopRunHitCleared", 32'(sensor_hit), 32'(0));
        tick(6);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        expSteps = stepsBefore(7);
        modelIdx = advance(modelIdx, 1'b1, 1'b1, expSteps);
        tick(HOLD_CYC - 1);
        checkOutput("stopHoldBusy", 32'(busy), 32'(1));
        checkOutput("stopHoldCoils", 32'(coils), 32'(phaseRef[modelIdx]));
        checkOutput("stopNoEarlyDone", 32'(done), 32'(0));
        checkOutput("stopSteps", 32'(step_count), 32'(expSteps));
        tick(1);
        checkOutput("stopDone", 32'(done), 32'(1));
        checkOutput("stopCoilsOff", 32'(coils), 32'(0));
        tick(1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(2);
        checkOutput("preResetCoilsOn", 32'(coils != 4'b0000), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetCoils", 32'(coils), 32'(0));
        checkOutput("asyncResetBusy", 32'(busy), 32'(0));
        checkOutput("asyncResetCount", 32'(step_count), 32'(0));
        rst_n = 1'b1;
        modelIdx = 0;
        tick(2);

        runMotion(1'b1, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
